// File: rtl/conv_feed_pkg.sv
// Shared types/constants for the convolution feed controller.
// CONV_FEED_FLUSH_EN adds the FLUSH state that pads the line buffer after the last pixel.
package conv_feed_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
`ifdef CONV_FEED_FLUSH_EN
    FLUSH = 3'd2,
`endif
    DRAIN = 3'd3,
    FIN   = 3'd4
  } feed_state_e;

  function automatic logic [ADDR_W-1:0] pix_total(input int w, input int h);
    return ADDR_W'(w * h);
  endfunction

endpackage

// File: rtl/conv_feed_if.sv
// Frame-control, memory-read and pixel-stream signals of conv_feed_ctrl.
// master = the controller, slave = memory/datapath/sequencer side.
interface conv_feed_if;
  import conv_feed_pkg::*;

  logic              start;
  logic              hold;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] din;
  logic              i_en;
  logic              busy;
  logic              done;

  modport master (
    input  start, hold, mem_rdata,
    output mem_addr, din, i_en, busy, done
  );

  modport slave (
    output start, hold, mem_rdata,
    input  mem_addr, din, i_en, busy, done
  );

endinterface

// File: rtl/conv_pace_cnt.sv
// Modulo-PACE counter: advances only while en, freezes otherwise; tc marks the PACE-1 step.
// tc is combinational from the registered count, so the caller acts on the same edge.
module conv_pace_cnt #(
  parameter int PACE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int              CNT_W = $clog2(PACE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PACE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tc    = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_feed_ctrl.sv
// Paces pixels from image memory into the conv line buffer: one registered strobe every PACE cycles, frozen by hold.
// Optional CONV_FEED_FLUSH_EN appends IMG_W+1 zero pixels; frame ends with a DRAIN_CYC wait and a done pulse.
module conv_feed_ctrl
  import conv_feed_pkg::*;
#(
  parameter int IMG_W     = 512,
  parameter int IMG_H     = 512,
  parameter int PACE      = 16,
  parameter int DRAIN_CYC = 64
) (
  input logic         clk,
  input logic         rst,
  conv_feed_if.master bus
);

  localparam logic [ADDR_W-1:0] PIX_LAST = pix_total(IMG_W, IMG_H) - 1'b1;
`ifdef CONV_FEED_FLUSH_EN
  localparam logic [ADDR_W-1:0] FLUSH_LAST = ADDR_W'(IMG_W);
`endif
  localparam int               DRN_W    = $clog2(DRAIN_CYC + 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYC - 1);

  feed_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [DRN_W-1:0]  drain_q, drain_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              i_en_q, i_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pace_clr, pace_en, pace_tc;

  conv_pace_cnt #(.PACE(PACE)) u_pace (
    .clk (clk),
    .rst (rst),
    .clr (pace_clr),
    .en  (pace_en),
    .tc  (pace_tc)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pix_d    = pix_q;
    drain_d  = drain_q;
    din_d    = din_q;
    i_en_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pace_clr = 1'b0;
    pace_en  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = FEED;
          addr_d   = '0;
          pix_d    = '0;
          busy_d   = 1'b1;
          pace_clr = 1'b1;
        end
      end
      FEED: begin
        pace_en = !bus.hold;
        if (pace_tc) begin
          din_d  = bus.mem_rdata;
          i_en_d = 1'b1;
          addr_d = addr_q + 1'b1;
          if (pix_q == PIX_LAST) begin
            drain_d = '0;
`ifdef CONV_FEED_FLUSH_EN
            pix_d   = '0;
            state_d = FLUSH;
`else
            pix_d   = pix_q + 1'b1;
            state_d = DRAIN;
`endif
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
`ifdef CONV_FEED_FLUSH_EN
      // Zero padding so the last image row fully propagates through the line buffer.
      FLUSH: begin
        pace_en = !bus.hold;
        if (pace_tc) begin
          din_d  = '0;
          i_en_d = 1'b1;
          pix_d  = pix_q + 1'b1;
          if (pix_q == FLUSH_LAST) begin
            drain_d = '0;
            state_d = DRAIN;
          end
        end
      end
`endif
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRN_LAST) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pix_q   <= '0;
      drain_q <= '0;
      din_q   <= '0;
      i_en_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      drain_q <= drain_d;
      din_q   <= din_d;
      i_en_q  <= i_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.din      = din_q;
  assign bus.i_en     = i_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_conv_feed_ctrl.sv
// Directed bench for conv_feed_ctrl on a 4x4 image, PACE=16, DRAIN_CYC=64, memory data[i]=i.
// Cycle numbers count rising edges; a value registered at edge k is sampled at the negedge that follows.
module tb_conv_feed_ctrl;
  import conv_feed_pkg::*;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int PACE = 16;
  localparam int DRN  = 64;
  localparam int NPIX = W * H;
`ifdef CONV_FEED_FLUSH_EN
  localparam int NSTB = NPIX + W + 1;
`else
  localparam int NSTB = NPIX;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  conv_feed_if bus ();

  conv_feed_ctrl #(
    .IMG_W     (W),
    .IMG_H     (H),
    .PACE      (PACE),
    .DRAIN_CYC (DRN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read image memory holding data[i] = i.
  always @(posedge clk) bus.mem_rdata <= 16'(bus.mem_addr);

  int          stb_cyc[$];
  logic [15:0] stb_din[$];
  int          done_n = 0;
  int          done_cyc = 0;
  logic        done_busy = 1'b1;

  always @(negedge clk) begin
    if (bus.i_en) begin
      stb_cyc.push_back(cyc);
      stb_din.push_back(bus.din);
    end
    if (bus.done) begin
      done_n    <= done_n + 1;
      done_cyc  <= cyc;
      done_busy <= bus.busy;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; start is seen by the DUT at the next rising edge.
  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int n = 0;
    while (done_n == base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    tick(1);
    check(tag, 32'(done_n - base), 1);
  endtask

  task automatic wait_live(input int k, input string tag);
    int seen = 0;
    int n = 0;
    while (seen < k && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
      if (bus.i_en) seen++;
    end
    check(tag, 32'(seen), 32'(k));
  endtask

  // gap4 = extra cycles expected between the 3rd and 4th strobes.
  task automatic check_frame(input int b, input int acc, input int fx, input int gap4, input string tag);
    check({tag, "_count"}, 32'(stb_cyc.size() - b), 32'(NSTB));
    if (stb_cyc.size() >= b + NSTB) begin
      check({tag, "_first"}, 32'(stb_cyc[b] - acc), 32'(PACE + fx));
      for (int i = 0; i < NSTB; i++) begin
        check({tag, "_din"}, 32'(stb_din[b+i]), (i < NPIX) ? 32'(i) : 32'd0);
        if (i > 0)
          check({tag, "_gap"}, 32'(stb_cyc[b+i] - stb_cyc[b+i-1]), (i == 3) ? 32'(PACE + gap4) : 32'(PACE));
      end
      check({tag, "_done_lat"}, 32'(done_cyc - stb_cyc[b+NSTB-1]), 32'(DRN));
      check({tag, "_done_busy"}, 32'(done_busy), 0);
    end
  endtask

  initial begin
    int b;
    int d;
    int acc;
    int bad;

    bus.start = 1'b0;
    bus.hold  = 1'b0;

    // Reset state
    tick(3);
    #1;
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_din",  32'(bus.din), 0);
    check("rst_ien",  32'(bus.i_en), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    rst = 1'b1;

    // Nominal frame, start seen at edge 10, first strobe at edge 26
    while (cyc < 9) @(negedge clk);
    b = stb_cyc.size();
    d = done_n;
    bus.start = 1'b1;
    #1;
    check("busy_before", 32'(bus.busy), 0);
    tick(1);
    bus.start = 1'b0;
    #1;
    check("busy_rise", 32'(bus.busy), 1);
    wait_done(d, "f1_done");
    check_frame(b, 10, 0, 0, "f1");
    check("addr_hold_end", 32'(bus.mem_addr), 32'(NPIX));
    check("busy_idle", 32'(bus.busy), 0);

    // Hold for 40 cycles right after the 3rd strobe
    tick(5);
    b = stb_cyc.size();
    d = done_n;
    acc = cyc + 1;
    pulse_start();
    wait_live(3, "f2_three");
    bus.hold = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus.i_en !== 1'b0) bad++;
      if (bus.mem_addr !== 19'd3) bad++;
    end
    bus.hold = 1'b0;
    check("f2_hold_quiet", 32'(bad), 0);
    wait_done(d, "f2_done");
    check_frame(b, acc, 0, 40, "f2");

    // start re-pulsed during FEED and during DRAIN is ignored
    tick(5);
    b = stb_cyc.size();
    d = done_n;
    acc = cyc + 1;
    pulse_start();
    tick(50);
    pulse_start();
    while (cyc < acc + PACE * NSTB + 20) @(negedge clk);
    pulse_start();
    wait_done(d, "f3_done");
    check_frame(b, acc, 0, 0, "f3");
    tick(100);
    check("f3_no_restart", 32'(stb_cyc.size() - b), 32'(NSTB));
    check("f3_busy_low", 32'(bus.busy), 0);

    // Reset just after the 7th strobe aborts the frame
    b = stb_cyc.size();
    d = done_n;
    pulse_start();
    wait_live(7, "f4_seven");
    rst = 1'b0;
    #1;
    check("abort_addr", 32'(bus.mem_addr), 0);
    check("abort_din",  32'(bus.din), 0);
    check("abort_ien",  32'(bus.i_en), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    tick(3);
    rst = 1'b1;
    tick(200);
    check("abort_no_done", 32'(done_n - d), 0);
    check("abort_idle", 32'(stb_cyc.size() - b), 7);
    b = stb_cyc.size();
    acc = cyc + 1;
    pulse_start();
    wait_done(d, "f5_done");
    check_frame(b, acc, 0, 0, "f5");

    // start and hold together: accepted, pacing frozen 9 extra edges
    tick(5);
    b = stb_cyc.size();
    d = done_n;
    acc = cyc + 1;
    bus.hold = 1'b1;
    pulse_start();
    #1;
    check("f6_busy", 32'(bus.busy), 1);
    tick(9);
    bus.hold = 1'b0;
    wait_done(d, "f6_done");
    check_frame(b, acc, 9, 0, "f6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
